// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: drives a combinational instruction memory and hands
// instructions to decode over a valid/ready link. Optional macro: FETCH_ECALL_HALT_EN.
module imem_fetch_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        halted,
    output logic        misalign_err
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StHalt} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] opc_q, opc_d;
    logic        misalign_q, misalign_d;
    logic        ecall_take;

    // Out-of-range indices are the memory's problem; the depth is informational only.
    logic unused_mem_words;
    assign unused_mem_words = ^MEM_WORDS;

    assign imem_addr    = {2'b00, pc_q[63:2]};
    assign out_valid    = valid_q;
    assign out_instr    = instr_q;
    assign out_pc       = opc_q;
    assign misalign_err = misalign_q;

`ifdef FETCH_ECALL_HALT_EN
    localparam logic [31:0] EcallInstr = 32'h0000_0073;
    assign ecall_take = valid_q && out_ready && (instr_q == EcallInstr);
    assign halted     = (state_q == StHalt);
`else
    assign ecall_take = 1'b0;
    assign halted     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        opc_d      = opc_q;
        misalign_d = misalign_q;

        if (state_q == StHalt) begin
            valid_d = 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins over any handshake; the held instruction is dropped.
            pc_d    = {redirect_pc[63:2], 2'b00};
            valid_d = 1'b0;
            state_d = StFetch;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StFetch;
                end
                StFetch, StHold: begin
                    if (!valid_q || out_ready) begin
                        if (ecall_take) begin
                            valid_d = 1'b0;
                            state_d = StHalt;
                        end else begin
                            // Transfer and next capture share one edge: no bubble.
                            instr_d = imem_data;
                            opc_d   = pc_q;
                            valid_d = 1'b1;
                            pc_d    = pc_q + 64'd4;
                            state_d = StFetch;
                        end
                    end else begin
                        state_d = StHold;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            opc_q      <= 64'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            opc_q      <= opc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule
